// File: rtl/parammod_pkg.sv
// -----------------------------------------------------------------------------
// parammod_pkg
// Shared definitions for the tree-PLRU state array.
//   - lru_word_t   : PLRU state word, sized for the widest supported
//                    associativity (MaxWay). Narrower configurations use only
//                    the low Way-1 bits; the rest ride along as zero.
//   - init_state_e : init sweep FSM states.
//   - tree_off()   : bit offset of the first node of a tree level.
// No ports (package).
// -----------------------------------------------------------------------------
package parammod_pkg;

  // Widest associativity the shared word type can hold.
  localparam int MaxWay   = 64;
  localparam int MaxStatW = MaxWay - 1;
  // Width of a node index into a full-width word (0..MaxStatW-1).
  localparam int NodeIdxW = $clog2(MaxStatW);

  typedef logic [MaxStatW-1:0] lru_word_t;

  typedef enum logic {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } init_state_e;

  // Level g of the tree starts at bit 2^g - 1 (root at bit 0).
  function automatic int tree_off(input int level);
    return (1 << level) - 1;
  endfunction

endpackage

// File: rtl/plru_tree.sv
// -----------------------------------------------------------------------------
// plru_tree
// Purely combinational tree-PLRU helper.
//   word_in   : current state word (full lru_word_t width, low Way-1 bits live)
//   way_in    : accessed way (hit or fill)
//   victim    : way selected by walking the tree from the root in word_in
//   word_next : word_in with every node on the path of way_in pointing away
//               from way_in; off-path nodes and unused upper bits unchanged
// Parameter Way: associativity (power of two, >= 2, <= MaxWay).
// -----------------------------------------------------------------------------
module plru_tree
  import parammod_pkg::*;
#(
  parameter int Way = 8,
  localparam int WaySel = $clog2(Way)
) (
  input  logic [MaxStatW-1:0] word_in,
  input  logic [WaySel-1:0]   way_in,
  output logic [WaySel-1:0]   victim,
  output logic [MaxStatW-1:0] word_next
);

  // Victim walk: the victim bits chosen so far double as the node index of
  // the next level, so the prefix is shifted left and the visited node bit is
  // appended as the next (lower) victim bit.
  logic [WaySel-1:0]   pfx;
  logic [NodeIdxW-1:0] pos_walk;

  always_comb begin
    pfx      = '0;
    pos_walk = '0;
    for (int g = 0; g < WaySel; g++) begin
      pos_walk = NodeIdxW'(tree_off(g)) + NodeIdxW'(pfx);
      pfx      = (pfx << 1) | WaySel'(word_in[pos_walk]);
    end
    victim = pfx;
  end

  // Update: at level g the path node index is the top g bits of way_in, and
  // the node is written to the inverse of way_in's bit at that level so the
  // walk steers away from the just-used way.
  logic [WaySel-1:0]   node_sh;
  logic [WaySel-1:0]   bit_sh;
  logic [NodeIdxW-1:0] pos_upd;

  always_comb begin
    word_next = word_in;
    node_sh   = '0;
    bit_sh    = '0;
    pos_upd   = '0;
    for (int g = 0; g < WaySel; g++) begin
      node_sh            = way_in >> (WaySel - g);
      bit_sh             = way_in >> (WaySel - 1 - g);
      pos_upd            = NodeIdxW'(tree_off(g)) + NodeIdxW'(node_sh);
      word_next[pos_upd] = ~bit_sh[0];
    end
  end

endmodule

// File: rtl/plru_array.sv
// -----------------------------------------------------------------------------
// plru_array
// Per-set tree-PLRU state array with victim lookup and access update.
//   clk       : single clock, all state on rising edge
//   reset     : asynchronous, active-high
//   init_done : high once the post-reset zeroing sweep has finished;
//               requests are ignored while it is low
//   rd_req/rd_set/rd_vld : victim lookup request, set, per-way valid mask
//   vic_valid/vic_way    : registered victim result, one cycle after rd_req
//   upd_req/upd_set/upd_way : access notification (hit or fill)
// Parameters: Way (associativity), Sets (number of sets), both powers of two.
// Optional feature macro LRU_INV_PRIO_EN: when defined, an invalid way in
// rd_vld (lowest index first) wins over the PLRU walk.
// -----------------------------------------------------------------------------
module plru_array
  import parammod_pkg::*;
#(
  parameter int Way  = 8,
  parameter int Sets = 64,
  localparam int LruStatW = Way - 1,
  localparam int WaySel   = $clog2(Way),
  localparam int SetSel   = $clog2(Sets)
) (
  input  logic              clk,
  input  logic              reset,
  output logic              init_done,
  input  logic              rd_req,
  input  logic [SetSel-1:0] rd_set,
  input  logic [Way-1:0]    rd_vld,
  output logic              vic_valid,
  output logic [WaySel-1:0] vic_way,
  input  logic              upd_req,
  input  logic [SetSel-1:0] upd_set,
  input  logic [WaySel-1:0] upd_way
);

  // State array: not reset, cleared by the init sweep instead.
  logic [LruStatW-1:0] lru_mem [Sets];

  init_state_e       state_reg, state_next;
  logic [SetSel-1:0] init_cnt_reg, init_cnt_next;
  logic              init_done_reg, init_done_next;
  logic              sweep_we;

  logic              vic_valid_reg;
  logic [WaySel-1:0] vic_way_reg;
  logic [WaySel-1:0] vic_sel;
  logic [WaySel-1:0] vic_plru;

  logic              rd_acc;
  logic              upd_acc;
  logic              fwd_hit;

  lru_word_t         upd_word_cur;
  lru_word_t         upd_word_new;
  lru_word_t         lkp_word;
  lru_word_t         lkp_word_next_unused;
  logic [WaySel-1:0] upd_victim_unused;
  logic              unused_sink;

  assign rd_acc  = rd_req  & init_done_reg;
  assign upd_acc = upd_req & init_done_reg;

  // ---------------------------------------------------------------------------
  // Init sweep FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= ST_INIT;
      init_cnt_reg  <= '0;
      init_done_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      init_cnt_reg  <= init_cnt_next;
      init_done_reg <= init_done_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    init_cnt_next  = init_cnt_reg;
    init_done_next = init_done_reg;
    sweep_we       = 1'b0;
    case (state_reg)
      ST_INIT: begin
        sweep_we      = 1'b1;
        init_cnt_next = init_cnt_reg + 1'b1;
        if (init_cnt_reg == SetSel'(Sets - 1)) begin
          state_next     = ST_READY;
          init_done_next = 1'b1;
        end
      end
      ST_READY: begin
        init_done_next = 1'b1;
      end
      default: begin
        state_next     = ST_INIT;
        init_done_next = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Update path: read-modify-write of the addressed word in one cycle
  // ---------------------------------------------------------------------------
  assign upd_word_cur = MaxStatW'(lru_mem[upd_set]);

  plru_tree #(.Way(Way)) u_tree_upd (
    .word_in   (upd_word_cur),
    .way_in    (upd_way),
    .victim    (upd_victim_unused),
    .word_next (upd_word_new)
  );

  always_ff @(posedge clk) begin
    if (sweep_we) begin
      lru_mem[init_cnt_reg] <= '0;
    end else if (upd_acc) begin
      lru_mem[upd_set] <= upd_word_new[LruStatW-1:0];
    end
  end

  // ---------------------------------------------------------------------------
  // Lookup path: a same-cycle update to the same set is forwarded so the
  // victim reflects the word as it will be after this edge.
  // ---------------------------------------------------------------------------
  assign fwd_hit  = upd_acc && (upd_set == rd_set);
  assign lkp_word = fwd_hit ? upd_word_new : MaxStatW'(lru_mem[rd_set]);

  plru_tree #(.Way(Way)) u_tree_lkp (
    .word_in   (lkp_word),
    .way_in    ('0),
    .victim    (vic_plru),
    .word_next (lkp_word_next_unused)
  );

`ifdef LRU_INV_PRIO_EN
  // Filling an empty way beats evicting a live one; lowest index wins.
  logic [Way-1:0] vld_sh;

  always_comb begin
    vic_sel = vic_plru;
    vld_sh  = '0;
    for (int i = Way - 1; i >= 0; i--) begin
      vld_sh = rd_vld >> i;
      if (!vld_sh[0]) begin
        vic_sel = WaySel'(i);
      end
    end
  end

  assign unused_sink = ^{lkp_word_next_unused, upd_victim_unused, upd_word_new};
`else
  assign vic_sel     = vic_plru;
  assign unused_sink = ^{lkp_word_next_unused, upd_victim_unused, upd_word_new, rd_vld};
`endif

  // ---------------------------------------------------------------------------
  // Registered result
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vic_valid_reg <= 1'b0;
      vic_way_reg   <= '0;
    end else begin
      vic_valid_reg <= rd_acc;
      if (rd_acc) begin
        vic_way_reg <= vic_sel;
      end
    end
  end

  assign init_done = init_done_reg;
  assign vic_valid = vic_valid_reg;
  assign vic_way   = vic_way_reg;

endmodule

// File: tb/tb_plru_array.sv
// -----------------------------------------------------------------------------
// tb_plru_array
// Self-checking bench for plru_array with Way=4, Sets=4. Stimulus pushes the
// expected victim into a queue; a negedge monitor pops and compares whenever
// vic_valid is seen, and flags results that are missing, late or unexpected.
// The reference model keeps each set's tree as an array of node bits and
// derives paths with integer division.
// -----------------------------------------------------------------------------
module tb_plru_array;

  localparam int W  = 4;
  localparam int S  = 4;
  localparam int WS = 2;
  localparam logic [3:0] F = 4'b1111;

  logic       clk;
  logic       reset;
  logic       init_done;
  logic       rd_req;
  logic [1:0] rd_set;
  logic [3:0] rd_vld;
  logic       vic_valid;
  logic [1:0] vic_way;
  logic       upd_req;
  logic [1:0] upd_set;
  logic [1:0] upd_way;

  plru_array #(.Way(W), .Sets(S)) dut (
    .clk       (clk),
    .reset     (reset),
    .init_done (init_done),
    .rd_req    (rd_req),
    .rd_set    (rd_set),
    .rd_vld    (rd_vld),
    .vic_valid (vic_valid),
    .vic_way   (vic_way),
    .upd_req   (upd_req),
    .upd_set   (upd_set),
    .upd_way   (upd_way)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int passes = 0;

  typedef struct {
    int way;
    int due;
  } exp_t;
  exp_t q[$];

  // Reference model: tree_m[s][n] is node n of set s (root n=0).
  int tree_m [S][W-1];

  function automatic void model_clear();
    for (int s = 0; s < S; s++)
      for (int n = 0; n < W - 1; n++)
        tree_m[s][n] = 0;
  endfunction

  function automatic void model_update(input int s, input int w);
    int node, b;
    for (int g = 0; g < WS; g++) begin
      node = w / (2 ** (WS - g));
      b    = (w / (2 ** (WS - 1 - g))) % 2;
      tree_m[s][(2 ** g) - 1 + node] = 1 - b;
    end
  endfunction

  function automatic int model_victim(input int s, input logic [3:0] vld);
    int node, v, b;
`ifdef LRU_INV_PRIO_EN
    for (int i = 0; i < W; i++)
      if (vld[i] == 1'b0) return i;
`endif
    node = 0;
    v    = 0;
    for (int g = 0; g < WS; g++) begin
      b    = tree_m[s][(2 ** g) - 1 + node];
      v    = v * 2 + b;
      node = node * 2 + b;
    end
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act == exp) begin
      passes++;
      $display("check %s: %0d", name, act);
    end else begin
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One request cycle, driven just after a negedge. exp < 0 means "ask the
  // model"; otherwise the given constant is the required victim.
  task automatic step(input logic rd, input logic [1:0] rs, input logic [3:0] vld,
                      input logic up, input logic [1:0] us, input logic [1:0] uw,
                      input int exp);
    exp_t e;
    rd_req  = rd;
    rd_set  = rs;
    rd_vld  = vld;
    upd_req = up;
    upd_set = us;
    upd_way = uw;
    if (up) model_update(int'(us), int'(uw));
    if (rd) begin
      e.way = (exp < 0) ? model_victim(int'(rs), vld) : exp;
      e.due = cyc + 1;
      q.push_back(e);
    end
    @(negedge clk);
    rd_req  = 1'b0;
    upd_req = 1'b0;
  endtask

  task automatic wait_init(output int n);
    n = 0;
    while (init_done !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (q.size() > 0 && k < 10) begin
      @(negedge clk);
      k++;
    end
    chk("drain_empty", q.size(), 0);
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    exp_t e;
    if (vic_valid === 1'b1) begin
      checks++;
      if (q.size() == 0) begin
        $display("FAIL unexpected_valid: got vic_way=%0d at cycle %0d, required no result", vic_way, cyc);
      end else begin
        e = q.pop_front();
        if (e.due == cyc && int'(vic_way) == e.way) begin
          passes++;
          $display("txn vic_way=%0d cycle %0d", vic_way, cyc);
        end else begin
          $display("FAIL vic_way: got %0d at cycle %0d, required %0d at cycle %0d",
                   vic_way, cyc, e.way, e.due);
        end
      end
    end else if (q.size() > 0 && q[0].due <= cyc) begin
      e = q.pop_front();
      checks++;
      $display("FAIL missing_valid: got vic_valid=0 at cycle %0d, required vic_way=%0d", cyc, e.way);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset   = 1'b1;
    rd_req  = 1'b0;
    rd_set  = '0;
    rd_vld  = F;
    upd_req = 1'b0;
    upd_set = '0;
    upd_way = '0;
    model_clear();

    repeat (2) @(negedge clk);
    chk("reset_init_done", int'(init_done), 0);
    chk("reset_vic_valid", int'(vic_valid), 0);
    chk("reset_vic_way", int'(vic_way), 0);

    // Release; requests held high during the sweep must be ignored.
    reset   = 1'b0;
    rd_req  = 1'b1;
    rd_set  = 2'd1;
    upd_req = 1'b1;
    upd_set = 2'd1;
    upd_way = 2'd0;
    wait_init(n);
    rd_req  = 1'b0;
    upd_req = 1'b0;
    chk("init_latency", n, 4);

    // Directed scenarios (constants derived by hand from the tree rules).
    step(1, 2'd0, F, 0, 2'd0, 2'd0, 0);          // fresh set -> way 0
    step(0, 2'd0, F, 1, 2'd1, 2'd0, -1);         // set1 <- 011
    step(1, 2'd1, F, 0, 2'd0, 2'd0, 2);
    step(0, 2'd0, F, 1, 2'd1, 2'd2, -1);         // set1 <- 110
    step(1, 2'd1, F, 0, 2'd0, 2'd0, 1);
    step(1, 2'd0, F, 0, 2'd0, 2'd0, 0);
    step(1, 2'd2, F, 1, 2'd2, 2'd0, 2);          // same-cycle forward
    step(0, 2'd0, F, 1, 2'd3, 2'd0, -1);         // set3 <- 011
    step(1, 2'd3, 4'b1011, 0, 2'd0, 2'd0, 2);
    step(1, 2'd3, F, 0, 2'd0, 2'd0, 2);
`ifdef LRU_INV_PRIO_EN
    step(1, 2'd3, 4'b1101, 0, 2'd0, 2'd0, 1);
`else
    step(1, 2'd3, 4'b1101, 0, 2'd0, 2'd0, 2);
`endif
    step(1, 2'd1, F, 1, 2'd0, 2'd1, 1);          // other-set update, no forward

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      logic [3:0] v;
      v = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : F;
      step(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), v,
           1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), -1);
    end
    drain();

    // In-flight result is dropped by reset.
    rd_req = 1'b1;
    rd_set = 2'd1;
    rd_vld = F;
    @(posedge clk);
    #1 rd_req = 1'b0;
    #1 chk("inflight_valid", int'(vic_valid), 1);
    reset = 1'b1;
    #1 chk("reset_drops_valid", int'(vic_valid), 0);
    chk("reset_clears_init_done", int'(init_done), 0);
    @(negedge clk);
    reset = 1'b0;

    // Abort the sweep after its second edge, then require a full re-sweep.
    @(posedge clk);
    @(posedge clk);
    #2 reset = 1'b1;
    #1 chk("abort_vic_valid", int'(vic_valid), 0);
    chk("abort_init_done", int'(init_done), 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    wait_init(n);
    chk("resweep_latency", n, 4);
    model_clear();

    step(1, 2'd1, F, 0, 2'd0, 2'd0, 0);          // set1 was cleared
    step(1, 2'd3, F, 0, 2'd0, 2'd0, 0);
    for (int i = 0; i < 60; i++) begin
      step(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), F,
           1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), -1);
    end
    drain();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
